cpu_axi_bridge: RTL and testbench

Converts the pipeline's two request/acknowledge memory ports (instruction fetch and data access) into a single AXI3 master port. It sits between the CPU core and the SoC interconnect, directly downstream of the core's `inst_sram_*` and `data_sram_*` interfaces. Those interfaces are upgraded from fixed-latency SRAM to `req`/`addr_ok`/`data_ok` handshakes. The bridge allows one outstanding read and one outstanding write, and it blocks read-after-write hazards.

---
 rtl/cpu_axi_pkg.sv | 17 +
 rtl/axi_rd_arbiter.sv | 54 +++++
 rtl/cpu_axi_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge.
package cpu_axi_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_e;

  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;
  localparam logic [3:0] ID_WR          = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Core size codes are bytes-log2 already; AXI just wants a third bit.
  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return {1'b0, sz};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Read-grant arbiter: fetch vs. data load, with read-after-write blocking.
// BRIDGE_DATA_PRIORITY_EN defined: loads always win a contested grant.
// Undefined: round-robin on a 1-bit last-grant register (reset = data).
module axi_rd_arbiter
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_idle_i,
  input  logic        wr_busy_i,
  input  logic [29:0] wr_word_i,
  input  logic        inst_req_i,
  input  logic [29:0] inst_word_i,
  input  logic        load_req_i,
  input  logic [29:0] load_word_i,
  output logic        inst_gnt_o,
  output logic        load_gnt_o
);

  logic inst_ok, load_ok;

  // A read of the word a pending store targets must wait for the B response.
  assign inst_ok = inst_req_i & ~(wr_busy_i & (inst_word_i == wr_word_i));
  assign load_ok = load_req_i & ~(wr_busy_i & (load_word_i == wr_word_i));

`ifdef BRIDGE_DATA_PRIORITY_EN
  logic unused_arb;
  assign unused_arb = clk ^ reset;

  // Fixed priority: the load wins whenever it is eligible.
  always_comb begin
    load_gnt_o = rd_idle_i & load_ok;
    inst_gnt_o = rd_idle_i & inst_ok & ~load_ok;
  end
`else
  logic last_data_q, last_data_d;

  // Round-robin: on contention the port that did not win last time goes next.
  always_comb begin
    load_gnt_o  = rd_idle_i & load_ok & (~inst_ok | ~last_data_q);
    inst_gnt_o  = rd_idle_i & inst_ok & (~load_ok |  last_data_q);
    last_data_d = last_data_q;
    if (load_gnt_o)      last_data_d = 1'b1;
    else if (inst_gnt_o) last_data_d = 1'b0;
  end

  // Remember which port took the most recent read grant.
  always_ff @(posedge clk) begin
    if (reset) last_data_q <= 1'b1;
    else       last_data_q <= last_data_d;
  end
`endif

endmodule

// File: rtl/cpu_axi_bridge.sv
// Fetch + load/store req/addr_ok/data_ok ports onto one AXI3 master.
// One outstanding read, one outstanding write, RAW-blocked reads.
// Optional BRIDGE_DATA_PRIORITY_EN selects fixed load priority on reads.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   rd_state_q;
  wr_state_e   wr_state_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q, rready_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q;

  logic rd_idle, wr_busy, inst_gnt, load_gnt, store_gnt;
  logic r_hs, b_hs, aw_done, w_done;

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign rd_idle   = (rd_state_q == RD_IDLE) & ~reset;
  assign wr_busy   = (wr_state_q != WR_IDLE);
  assign store_gnt = (wr_state_q == WR_IDLE) & ~reset & data_req & data_wr;

  axi_rd_arbiter u_rd_arb (
    .clk         (clk),
    .reset       (reset),
    .rd_idle_i   (rd_idle),
    .wr_busy_i   (wr_busy),
    .wr_word_i   (awaddr_q[31:2]),
    .inst_req_i  (inst_req),
    .inst_word_i (inst_addr[31:2]),
    .load_req_i  (data_req & ~data_wr),
    .load_word_i (data_addr[31:2]),
    .inst_gnt_o  (inst_gnt),
    .load_gnt_o  (load_gnt)
  );

  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = load_gnt | store_gnt;

  // Completions come straight off the R/B handshakes, routed by ID.
  assign r_hs         = rvalid & rready_q;
  assign b_hs         = bvalid & bready_q;
  assign inst_data_ok = r_hs & (rid == ID_INST);
  assign data_data_ok = (r_hs & (rid == ID_DATA)) | b_hs;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // Read FSM: latch the granted request, drive AR, then accept one R beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      arid_q     <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (inst_gnt | load_gnt) begin
          rd_state_q <= RD_AR;
          arvalid_q  <= 1'b1;
          if (load_gnt) begin
            arid_q   <= ID_DATA;
            araddr_q <= data_addr;
            arsize_q <= axi_size(data_size);
          end else begin
            arid_q   <= ID_INST;
            araddr_q <= inst_addr;
            arsize_q <= axi_size(inst_size);
          end
        end
        RD_AR: if (arready) begin
          rd_state_q <= RD_R;
          arvalid_q  <= 1'b0;
          rready_q   <= 1'b1;
        end
        RD_R: if (rvalid) begin
          rd_state_q <= RD_IDLE;
          rready_q   <= 1'b0;
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // AW and W retire independently; either order or together.
  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q  | wready;

  // Write FSM: latch the store, run AW/W in parallel, then wait for B.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: if (store_gnt) begin
          wr_state_q <= WR_AW_W;
          awaddr_q   <= data_addr;
          awsize_q   <= axi_size(data_size);
          wdata_q    <= data_wdata;
          wstrb_q    <= data_wstrb;
          awvalid_q  <= 1'b1;
          wvalid_q   <= 1'b1;
        end
        WR_AW_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done & w_done) begin
            wr_state_q <= WR_B;
            bready_q   <= 1'b1;
          end
        end
        WR_B: if (bvalid) begin
          wr_state_q <= WR_IDLE;
          bready_q   <= 1'b0;
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = 4'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = ID_WR;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = 4'd0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = ID_WR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Responses and single-beat markers carry nothing the core needs.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: scripted AXI slave, transaction-level model.
module tb_cpu_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req;   logic [1:0] inst_size;  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;         logic [31:0] inst_rdata;
  logic        data_req, data_wr; logic [1:0] data_size; logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;         logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache; logic [31:0] araddr; logic [2:0] arsize, arprot;
  logic [1:0]  arburst, arlock; logic arvalid, arready;
  logic [3:0]  rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache; logic [31:0] awaddr; logic [2:0] awsize, awprot;
  logic [1:0]  awburst, awlock; logic awvalid, awready;
  logic [3:0]  wid, wstrb; logic [31:0] wdata; logic wlast, wvalid, wready;
  logic [3:0]  bid; logic [1:0] bresp; logic bvalid, bready;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  logic last_data;   // model: most recent read grant went to the data port

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // drive just after the active edge, sample on the falling edge
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic clear_in();
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;
  endtask

  function automatic logic exp_data_wins();
`ifdef BRIDGE_DATA_PRIORITY_EN
    return 1'b1;
`else
    return !last_data;
`endif
  endfunction

  // Single read through one port, with AR and R wait states.
  task automatic do_read(input bit port, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] rd, input int arw, input int rw);
    cyc();
    if (port) begin data_req = 1; data_wr = 0; data_addr = addr; data_size = size; end
    else begin inst_req = 1; inst_addr = addr; inst_size = size; end
    smp();
    chk("rd_inst_addr_ok", inst_addr_ok, !port);
    chk("rd_data_addr_ok", data_addr_ok, port);
    last_data = port;
    for (int k = 0; k <= arw; k++) begin
      cyc(); inst_req = 0; data_req = 0; arready = (k == arw);
      smp();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arsize", arsize, {1'b0, size});
      chk("arid", arid, port ? 32'd1 : 32'd0);
      chk("rready_in_ar", rready, 0);
    end
    for (int k = 0; k <= rw; k++) begin
      cyc(); arready = 0; rvalid = (k == rw); rid = port ? 4'd1 : 4'd0; rdata = rd;
      inst_req = (k == rw);   // must not be granted in the data_ok cycle
      smp();
      chk("arvalid_drop", arvalid, 0);
      chk("rready_in_r", rready, 1);
      chk("inst_data_ok", inst_data_ok, (k == rw) && !port);
      chk("data_data_ok", data_data_ok, (k == rw) && port);
      if (k == rw) begin
        chk("rdata", port ? data_rdata : inst_rdata, rd);
        chk("no_grant_on_data_ok", inst_addr_ok, 0);
      end
    end
    cyc(); rvalid = 0; inst_req = 0;
    smp();
    chk("rready_idle", rready, 0);
  endtask

  // Single store with independent AW/W ready delays and a B delay.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] strb,
                          input logic [31:0] wd, input int aww, input int ww, input int bw);
    bit aw_p, w_p;
    int mx;
    cyc();
    data_req = 1; data_wr = 1; data_addr = addr; data_size = size; data_wstrb = strb; data_wdata = wd;
    smp();
    chk("wr_addr_ok", data_addr_ok, 1);
    aw_p = 1; w_p = 1;
    mx = (aww > ww) ? aww : ww;
    for (int k = 0; k <= mx; k++) begin
      cyc(); data_req = 0; data_wr = 0; awready = (k >= aww); wready = (k >= ww);
      smp();
      chk("awvalid", awvalid, aw_p);
      chk("wvalid", wvalid, w_p);
      chk("bready_early", bready, 0);
      if (aw_p) begin chk("awaddr", awaddr, addr); chk("awsize", awsize, {1'b0, size}); end
      if (w_p)  begin chk("wdata", wdata, wd); chk("wstrb", wstrb, strb); end
      if (k >= aww) aw_p = 0;
      if (k >= ww)  w_p  = 0;
    end
    for (int k = 0; k <= bw; k++) begin
      cyc(); awready = 0; wready = 0; bvalid = (k == bw);
      smp();
      chk("bready", bready, 1);
      chk("aw_w_quiet", {awvalid, wvalid}, 0);
      chk("store_data_ok", data_data_ok, (k == bw));
    end
    cyc(); bvalid = 0;
    smp();
    chk("bready_idle", bready, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ed;
    logic [31:0] v;
    clear_in();
    reset = 1;
    // reset state, with requests present that must not be accepted
    repeat (2) cyc();
    inst_req = 1; data_req = 1; data_wr = 1;
    smp();
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("const_ids", {awid, wid, wlast}, 9'b0001_0001_1);
    chk("const_ar", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_aw", {awlen, awburst, awlock, awcache, awprot}, {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    cyc(); reset = 0; clear_in();
    last_data = 1;

    // fetch with R two cycles after the AR handshake
    do_read(0, 32'h1C00_0000, 2'd2, 32'h0280_0404, 0, 1);
    // store with W ready three cycles after AW
    do_write(32'h8000_0010, 2'd2, 4'b0011, $urandom, 0, 3, 1);
    do_write(32'h8000_0020, 2'd1, 4'b1100, $urandom, 2, 0, 0);

    // RAW: store to 0x100 outstanding, load of 0x102 held off until after B
    cyc(); data_req = 1; data_wr = 1; data_addr = 32'h100; data_size = 2;
    data_wstrb = 4'hF; data_wdata = $urandom;
    smp(); chk("raw_store_ok", data_addr_ok, 1);
    cyc(); data_wr = 0; data_addr = 32'h102; data_size = 1; awready = 1; wready = 1;
    inst_req = 1; inst_addr = 32'h103;
    smp();
    chk("raw_load_blk", data_addr_ok, 0);
    chk("raw_fetch_blk", inst_addr_ok, 0);
    for (int k = 0; k <= 3; k++) begin
      cyc(); awready = 0; wready = 0; inst_req = 0; bvalid = (k == 3);
      smp();
      chk("raw_hold", data_addr_ok, 0);
      chk("raw_b_ok", data_data_ok, (k == 3));
    end
    cyc(); bvalid = 0;
    smp(); chk("raw_grant", data_addr_ok, 1);
    last_data = 1;
    cyc(); data_req = 0; arready = 1;
    smp();
    chk("raw_araddr", araddr, 32'h102);
    chk("raw_arid", arid, 1);
    v = $urandom;
    cyc(); arready = 0; rvalid = 1; rid = 1; rdata = v;
    smp();
    chk("raw_load_ok", data_data_ok, 1);
    chk("raw_rdata", data_rdata, v);
    cyc(); rvalid = 0;

    // contention: both ports request a read in the same cycle, four times
    for (int g = 0; g < 4; g++) begin
      cyc();
      inst_req = 1; inst_addr = 32'h1C00_0000 + 32'(g * 4); inst_size = 2;
      data_req = 1; data_wr = 0; data_addr = 32'h9000_0000 + 32'(g * 4); data_size = 2;
      smp();
      ed = exp_data_wins();
      chk("cont_data_gnt", data_addr_ok, ed);
      chk("cont_inst_gnt", inst_addr_ok, !ed);
      last_data = ed;
      cyc(); inst_req = 0; data_req = 0; arready = 1;
      smp();
      chk("cont_arid", arid, ed);
      chk("cont_araddr", araddr, ed ? 32'h9000_0000 + 32'(g * 4) : 32'h1C00_0000 + 32'(g * 4));
      v = $urandom;
      cyc(); arready = 0; rvalid = 1; rid = {3'd0, ed}; rdata = v;
      smp();
      chk("cont_done", ed ? data_data_ok : inst_data_ok, 1);
      cyc(); rvalid = 0;
    end

    // load R and store B completing in the same cycle
    cyc(); data_req = 1; data_wr = 0; data_addr = 32'h2000; data_size = 2;
    smp(); chk("sim_load_ok", data_addr_ok, 1);
    last_data = 1;
    cyc(); data_wr = 1; data_addr = 32'h3000; data_wdata = $urandom; data_wstrb = 4'hF; arready = 1;
    smp(); chk("sim_store_ok", data_addr_ok, 1);
    cyc(); data_req = 0; data_wr = 0; arready = 0; awready = 1; wready = 1;
    smp(); chk("sim_rready", rready, 1);
    cyc(); awready = 0; wready = 0; rvalid = 1; rid = 1; rdata = $urandom; bvalid = 1;
    smp();
    chk("sim_both_ready", {rready, bready}, 2'b11);
    chk("sim_data_ok", data_data_ok, 1);
    chk("sim_inst_ok", inst_data_ok, 0);
    cyc(); rvalid = 0; bvalid = 0;
    smp();
    chk("sim_idle", {rready, bready, arvalid, awvalid, wvalid}, 0);

    // reset while waiting on R
    cyc(); inst_req = 1; inst_addr = 32'h1C00_0040; inst_size = 2;
    smp(); chk("rst_fetch_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0; arready = 1;
    smp();
    cyc(); arready = 0;
    smp(); chk("rst_in_r", rready, 1);
    cyc(); reset = 1;
    smp();
    cyc(); reset = 0; inst_req = 1; inst_addr = 32'h1C00_0080; rvalid = 1; rid = 0;
    smp();
    chk("post_rst_rready", rready, 0);
    chk("post_rst_no_ok", inst_data_ok, 0);
    chk("post_rst_accept", inst_addr_ok, 1);
    last_data = 0;
    cyc(); inst_req = 0; rvalid = 0; arready = 1;
    smp(); chk("post_rst_araddr", araddr, 32'h1C00_0080);
    v = $urandom;
    cyc(); arready = 0; rvalid = 1; rid = 0; rdata = v;
    smp();
    chk("post_rst_done", inst_data_ok, 1);
    chk("post_rst_rdata", inst_rdata, v);
    cyc(); rvalid = 0;

    // randomized single transactions with random wait states
    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 2)
        do_write($urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(op[0], $urandom, 2'($urandom_range(0, 2)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
